// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM style master port bundle shared by both requesters of the RAM arbiter.
// "master" is the requester side and "slave" is the arbiter side.
interface onchip_mem_arbiter_if #(
    parameter int AW = 13
);
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic          waitrequest;
    logic [31:0]   readdata;
    logic          readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 32-bit on-chip RAM.
// Grants one access per cycle; read data returns one cycle later, tagged to its issuer.
module onchip_mem_arbiter #(
    parameter int DEPTH = 5000,
    parameter int AW    = 13
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_arbiter_if.slave m0,
    onchip_mem_arbiter_if.slave m1,
    output logic [AW-1:0]       mem_address,
    output logic [3:0]          mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [31:0]         mem_writedata,
    output logic                mem_clken,
    input  logic [31:0]         mem_readdata
);
    typedef enum logic {IDLE, RETURN} rd_state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    rd_state_t   state_reg, state_next;
    logic        prio_reg, prio_next;
    logic        rd_owner_reg, rd_owner_next;
    logic        rd_oor_reg, rd_oor_next;

    logic [1:0]    rd, wr, req, wait_out, valid_out;
    logic [AW-1:0] addr [2];
    logic [3:0]    be [2];
    logic [31:0]   wdata [2];
    logic [31:0]   rdata_out [2];

    logic        grant_valid;
    logic        gnt;
    logic        gnt_read;
    logic        in_range;
    logic        accept_read;
    logic [31:0] ret_data;

    assign rd       = {m1.read, m0.read};
    assign wr       = {m1.write, m0.write};
    assign addr[0]  = m0.address;
    assign addr[1]  = m1.address;
    assign be[0]    = m0.byteenable;
    assign be[1]    = m1.byteenable;
    assign wdata[0] = m0.writedata;
    assign wdata[1] = m1.writedata;

    // Out-of-range reads are still acknowledged but must return zeros.
    assign ret_data = rd_oor_reg ? 32'h0 : mem_readdata;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign req[gi]       = rd[gi] | wr[gi];
            assign wait_out[gi]  = ~(grant_valid & (gnt == 1'(gi)));
            assign valid_out[gi] = reset_n & (state_reg == RETURN) & (rd_owner_reg == 1'(gi));
            assign rdata_out[gi] = valid_out[gi] ? ret_data : 32'h0;
        end
    endgenerate

    assign m0.waitrequest   = wait_out[0];
    assign m1.waitrequest   = wait_out[1];
    assign m0.readdatavalid = valid_out[0];
    assign m1.readdatavalid = valid_out[1];
    assign m0.readdata      = rdata_out[0];
    assign m1.readdata      = rdata_out[1];

    always_comb begin
        grant_valid    = reset_n & (|req);
        gnt            = (&req) ? prio_reg : req[1];
        // A simultaneous read+write strobe is treated as a write.
        gnt_read       = rd[gnt] & ~wr[gnt];
        in_range       = {1'b0, addr[gnt]} < DEPTH_W;
        accept_read    = grant_valid & gnt_read;

        mem_address    = addr[gnt];
        mem_byteenable = be[gnt];
        mem_writedata  = wdata[gnt];
        mem_chipselect = grant_valid & in_range;
        mem_write      = grant_valid & in_range & wr[gnt];
        mem_clken      = reset_n;

        prio_next      = grant_valid ? ~gnt : prio_reg;
        state_next     = accept_read ? RETURN : IDLE;
        rd_owner_next  = accept_read ? gnt : rd_owner_reg;
        rd_oor_next    = accept_read ? ~in_range : rd_oor_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            prio_reg     <= 1'b0;
            rd_owner_reg <= 1'b0;
            rd_oor_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prio_reg     <= prio_next;
            rd_owner_reg <= rd_owner_next;
            rd_oor_reg   <= rd_oor_next;
        end
    end
endmodule
